// File: rtl/wdg_ctrl.sv
// Two-stage watchdog: stage 1 raises irq_wdg, stage 2 latches rst_req.
// Config/kick through a single-cycle register port; counting advances on mtick.
module wdg_ctrl #(
  parameter int          WIDTH = 16,
  parameter logic [31:0] KEY   = 32'h5A5A_C0DE
) (
  input  logic        sys_clk,
  input  logic        res,
  input  logic        mtick,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        irq_wdg,
  output logic        rst_req,
  output logic [1:0]  wdg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN1    = 2'd1,
    RUN2    = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t           state;
  logic             en;
  logic             lock;
  logic [WIDTH-1:0] thr1;
  logic [WIDTH-1:0] thr2;
  logic [WIDTH-1:0] count;

  logic running;
  logic cfg_open;
  logic wr_ctrl;
  logic wr_thr1;
  logic wr_thr2;
  logic kick;
  logic good_kick;
  logic bad_kick;

  assign running   = (state == RUN1) || (state == RUN2);
  // Configuration is closed both by lock and once the watchdog has fired.
  assign cfg_open  = cfg_we && !lock && (state != EXPIRED);
  assign wr_ctrl   = cfg_open && (cfg_addr == 2'd0);
  assign wr_thr1   = cfg_open && (cfg_addr == 2'd1);
  assign wr_thr2   = cfg_open && (cfg_addr == 2'd2);
  assign kick      = cfg_we && (cfg_addr == 2'd3) && running;
  assign good_kick = kick && (cfg_wdata == KEY);
  assign bad_kick  = kick && (cfg_wdata != KEY);

  assign wdg_state = state;

  always_ff @(posedge sys_clk or posedge res) begin
    if (res) begin
      state   <= IDLE;
      en      <= 1'b0;
      lock    <= 1'b0;
      thr1    <= '1;
      thr2    <= '1;
      count   <= '0;
      irq_wdg <= 1'b0;
      rst_req <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en   <= cfg_wdata[0];
        lock <= lock | cfg_wdata[1];
      end
      if (wr_thr1) thr1 <= cfg_wdata[WIDTH-1:0];
      if (wr_thr2) thr2 <= cfg_wdata[WIDTH-1:0];

      case (state)
        IDLE: begin
          if (wr_ctrl && cfg_wdata[0]) begin
            state <= RUN1;
            count <= '0;
          end
        end
        RUN1, RUN2: begin
          // Priority: bad kick, then valid kick, then disable, then tick.
          if (bad_kick) begin
            state   <= EXPIRED;
            irq_wdg <= 1'b1;
            rst_req <= 1'b1;
          end else if (good_kick) begin
            state   <= RUN1;
            count   <= '0;
            irq_wdg <= 1'b0;
          end else if (wr_ctrl && !cfg_wdata[0]) begin
            state   <= IDLE;
            count   <= '0;
            irq_wdg <= 1'b0;
          end else if (mtick) begin
            if (state == RUN1) begin
              if (count == thr1) begin
                state   <= RUN2;
                count   <= '0;
                irq_wdg <= 1'b1;
              end else begin
                count <= count + WIDTH'(1);
              end
            end else begin
              if (count == thr2) begin
                state   <= EXPIRED;
                rst_req <= 1'b1;
              end else begin
                count <= count + WIDTH'(1);
              end
            end
          end
        end
        default: begin
          irq_wdg <= 1'b1;
          rst_req <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0: cfg_rdata[1:0] = {lock, en};
      2'd1: cfg_rdata[WIDTH-1:0] = thr1;
      2'd2: cfg_rdata[WIDTH-1:0] = thr2;
      default: begin
        cfg_rdata[15+WIDTH:16] = count;
        cfg_rdata[1:0]         = state;
      end
    endcase
  end

endmodule

// File: tb/tb_wdg_ctrl.sv
// Directed table-driven bench for wdg_ctrl: each row drives one cycle of
// inputs, then checks state, irq, rst_req and one register readback.
module tb_wdg_ctrl;

  localparam logic [31:0] K = 32'h5A5A_C0DE;

  logic        sys_clk;
  logic        res;
  logic        mtick;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        irq_wdg;
  logic        rst_req;
  logic [1:0]  wdg_state;

  int checks;
  int failures;

  wdg_ctrl dut (
    .sys_clk   (sys_clk),
    .res       (res),
    .mtick     (mtick),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .irq_wdg   (irq_wdg),
    .rst_req   (rst_req),
    .wdg_state (wdg_state)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        tick;
    logic [1:0]  st;
    logic        irq;
    logic        rq;
    logic [1:0]  ra;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic we, input logic [1:0] addr,
                     input logic [31:0] wdata, input logic tick,
                     input logic [1:0] st, input logic irq, input logic rq,
                     input logic [1:0] ra, input logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.we = we; v.addr = addr; v.wdata = wdata; v.tick = tick;
    v.st = st; v.irq = irq; v.rq = rq; v.ra = ra; v.rd = rd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    res = 1'b1; mtick = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;

    // rst we addr wdata tick | st irq rq | read addr, expected rdata
    add(1,0,0,0,0, 0,0,0, 1,32'h0000_FFFF);
    add(0,0,0,0,0, 0,0,0, 2,32'h0000_FFFF);
    add(0,0,0,0,0, 0,0,0, 0,32'h0);
    add(0,0,0,0,1, 0,0,0, 3,32'h0);          // tick ignored in IDLE
    add(0,1,1,3,0, 0,0,0, 1,32'h3);
    add(0,1,2,2,0, 0,0,0, 2,32'h2);
    add(0,1,0,1,0, 1,0,0, 0,32'h1);
    add(0,0,0,0,1, 1,0,0, 3,32'h0001_0001);
    add(0,0,0,0,1, 1,0,0, 3,32'h0002_0001);
    add(0,0,0,0,1, 1,0,0, 3,32'h0003_0001);
    add(0,0,0,0,1, 2,1,0, 3,32'h0000_0002);  // 4th tick -> stage 1
    add(0,0,0,0,1, 2,1,0, 3,32'h0001_0002);
    add(0,0,0,0,1, 2,1,0, 3,32'h0002_0002);
    add(0,0,0,0,1, 3,1,1, 0,32'h1);          // stage 2 expiry
    add(0,1,3,K,0, 3,1,1, 0,32'h1);          // kick ignored once expired
    add(0,1,0,0,0, 3,1,1, 0,32'h1);          // CTRL write ignored
    add(0,0,0,0,1, 3,1,1, 0,32'h1);
    add(1,0,0,0,0, 0,0,0, 0,32'h0);
    // valid kick coincident with threshold tick
    add(0,1,1,3,0, 0,0,0, 1,32'h3);
    add(0,1,0,1,0, 1,0,0, 3,32'h0000_0001);
    add(0,0,0,0,1, 1,0,0, 3,32'h0001_0001);
    add(0,0,0,0,1, 1,0,0, 3,32'h0002_0001);
    add(0,0,0,0,1, 1,0,0, 3,32'h0003_0001);
    add(0,1,3,K,1, 1,0,0, 3,32'h0000_0001);
    add(0,0,0,0,1, 1,0,0, 3,32'h0001_0001);
    add(0,0,0,0,1, 1,0,0, 3,32'h0002_0001);
    add(0,0,0,0,1, 1,0,0, 3,32'h0003_0001);
    add(0,0,0,0,1, 2,1,0, 3,32'h0000_0002);
    add(0,1,3,K,0, 1,0,0, 3,32'h0000_0001);  // kick in RUN2
    add(0,0,0,0,1, 1,0,0, 3,32'h0001_0001);
    add(0,1,3,0,0, 3,1,1, 0,32'h1);          // bad key
    add(1,0,0,0,0, 0,0,0, 0,32'h0);
    // disable beats tick; kicks in IDLE are inert
    add(0,1,1,1,0, 0,0,0, 1,32'h1);
    add(0,1,0,1,0, 1,0,0, 3,32'h0000_0001);
    add(0,0,0,0,1, 1,0,0, 3,32'h0001_0001);
    add(0,1,0,0,1, 0,0,0, 3,32'h0);
    add(0,1,3,0,0, 0,0,0, 3,32'h0);
    add(0,1,0,1,0, 1,0,0, 3,32'h0000_0001);
    add(0,0,0,0,1, 1,0,0, 3,32'h0001_0001);
    add(0,0,0,0,1, 2,1,0, 3,32'h0000_0002);
    add(0,1,0,0,0, 0,0,0, 3,32'h0);          // disable from RUN2
    // lock
    add(0,1,0,3,0, 1,0,0, 0,32'h3);
    add(0,1,0,0,0, 1,0,0, 0,32'h3);
    add(0,1,1,0,0, 1,0,0, 1,32'h1);
    add(0,1,2,5,0, 1,0,0, 2,32'h0000_FFFF);
    add(0,0,0,0,1, 1,0,0, 3,32'h0001_0001);
    add(0,1,3,K,0, 1,0,0, 3,32'h0000_0001);  // kick still works when locked
    add(1,0,0,0,0, 0,0,0, 0,32'h0);
    add(0,1,1,0,0, 0,0,0, 1,32'h0);          // lock cleared by res
    add(0,1,0,1,0, 1,0,0, 0,32'h1);
    add(0,0,0,0,1, 2,1,0, 3,32'h0000_0002);  // thr1=0: first tick
    add(0,1,2,0,0, 2,1,0, 2,32'h0);
    add(0,0,0,0,1, 3,1,1, 0,32'h1);          // new thr2 used at next compare

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge sys_clk);
      res       = vecs[i].rst;
      cfg_we    = vecs[i].we;
      cfg_addr  = vecs[i].addr;
      cfg_wdata = vecs[i].wdata;
      mtick     = vecs[i].tick;
      @(posedge sys_clk);
      #1;
      res = 1'b0; cfg_we = 1'b0; mtick = 1'b0; cfg_wdata = '0;
      cfg_addr = vecs[i].ra;
      #1;
      chk("state",   i, 32'(wdg_state), 32'(vecs[i].st));
      chk("irq_wdg", i, 32'(irq_wdg),   32'(vecs[i].irq));
      chk("rst_req", i, 32'(rst_req),   32'(vecs[i].rq));
      chk("rdata",   i, cfg_rdata,      vecs[i].rd);
    end

    // asynchronous reset from EXPIRED, observed before any clock edge
    @(negedge sys_clk);
    #1;
    res = 1'b1;
    #1;
    cfg_addr = 2'd3;
    #1;
    chk("async_state", -1, 32'(wdg_state), 32'd0);
    chk("async_rst",   -1, 32'(rst_req),   32'd0);
    chk("async_irq",   -1, 32'(irq_wdg),   32'd0);
    chk("async_count", -1, cfg_rdata,      32'h0);
    res = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
